// File: rtl/ddr3_phy_pkg.sv
// Shared DDR PHY definitions: delay-line op codes,
// command FSM states and the direction polarity.
package ddr3_phy_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_NOP  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETDIR,
        S_MOVE,
        S_GAP,
        S_DONE
    } state_e;

    localparam logic DIR_INC = 1'b1;

endpackage

// File: rtl/ddr3_ca_delay_req_arb.sv
// Fixed-priority TRN/VT arbiter for the CA delay-line engine:
// grant, lane/op capture and routing of DONE back to the owner.
module ddr3_ca_delay_req_arb
    import ddr3_phy_pkg::*;
#(
    parameter int LANE_W = 4,
    parameter int TAP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic              trn_req,
    input  logic [LANE_W-1:0] trn_lane,
    input  logic [1:0]        trn_op,
    input  logic [TAP_W-1:0]  trn_steps,
    input  logic              vt_req,
    input  logic [LANE_W-1:0] vt_lane,
    input  logic [1:0]        vt_op,
    input  logic [TAP_W-1:0]  vt_steps,
    input  logic              done,
    output logic              trn_gnt,
    output logic              vt_gnt,
    output logic              gnt,
    output logic [LANE_W-1:0] sel_lane,
    output op_e               sel_op,
    output logic [TAP_W-1:0]  sel_steps,
    output logic [LANE_W-1:0] cap_lane,
    output op_e               cap_op,
    output logic              trn_done,
    output logic              vt_done
);

    logic owner_vt;

    // TRN always wins; the selected fields follow the winner
    always_comb begin
        trn_gnt   = accept & trn_req;
        vt_gnt    = accept & vt_req & ~trn_req;
        gnt       = trn_gnt | vt_gnt;
        sel_lane  = trn_req ? trn_lane : vt_lane;
        sel_op    = op_e'(trn_req ? trn_op : vt_op);
        sel_steps = trn_req ? trn_steps : vt_steps;
    end

    // Latch the granted request and remember who owns it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_vt <= 1'b0;
            cap_lane <= '0;
            cap_op   <= OP_NOP;
        end else if (gnt) begin
            owner_vt <= vt_gnt;
            cap_lane <= sel_lane;
            cap_op   <= sel_op;
        end
    end

    assign trn_done = done & ~owner_vt;
    assign vt_done  = done &  owner_vt;

endmodule

// File: rtl/ddr3_ca_delay_line_ctrl.sv
// DDR3 CA delay-line sequencer: LOAD/DIRECTION/MOVE pulse
// generation, range monitoring and per-lane shadow taps.
module ddr3_ca_delay_line_ctrl
    import ddr3_phy_pkg::*;
#(
    parameter int NUM_LANES = 14,
    parameter int LANE_W    = 4,
    parameter int TAP_W     = 8,
    parameter int LOAD_VAL  = 1,
    parameter int MAX_TAP   = 255,
    parameter int MOVE_GAP  = 2
) (
    input  logic                 FAB_CLK,
    input  logic                 RESET_N,
    input  logic                 TRN_REQ,
    input  logic [LANE_W-1:0]    TRN_LANE,
    input  logic [1:0]           TRN_OP,
    input  logic [TAP_W-1:0]     TRN_STEPS,
    output logic                 TRN_GNT,
    output logic                 TRN_DONE,
    input  logic                 VT_REQ,
    input  logic [LANE_W-1:0]    VT_LANE,
    input  logic [1:0]           VT_OP,
    input  logic [TAP_W-1:0]     VT_STEPS,
    output logic                 VT_GNT,
    output logic                 VT_DONE,
    output logic                 DONE_ERR,
    output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0] DELAY_LINE_DIRECTION,
    input  logic [NUM_LANES-1:0] DELAY_LINE_OUT_OF_RANGE,
    input  logic [LANE_W-1:0]    RD_LANE,
    output logic [TAP_W-1:0]     RD_TAP,
    output logic                 BUSY
);

    localparam int GAP_W = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
    localparam logic [LANE_W:0] LANES_V = (LANE_W+1)'(NUM_LANES);

    state_e               state, state_d;
    logic                 accept, gnt, sel_ok;
    logic [LANE_W-1:0]    sel_lane, cap_lane;
    op_e                  sel_op, cap_op;
    logic [TAP_W-1:0]     sel_steps, steps_left;
    logic [GAP_W-1:0]     gap_cnt;
    logic [NUM_LANES-1:0] lane_oh, dir_q;
    logic [TAP_W-1:0]     shadow [NUM_LANES];
    logic [TAP_W-1:0]     cur_tap, rd_sel;
    logic                 done_err_q, done_err_d, dir_load;
    logic                 sat, oor_hit, gap_last;
    logic                 move_fire, step_commit;

    assign accept = RESET_N && (state == S_IDLE);
    assign sel_ok = {1'b0, sel_lane} < LANES_V;

    ddr3_ca_delay_req_arb #(
        .LANE_W (LANE_W),
        .TAP_W  (TAP_W)
    ) u_arb (
        .clk       (FAB_CLK),
        .rst_n     (RESET_N),
        .accept    (accept),
        .trn_req   (TRN_REQ),
        .trn_lane  (TRN_LANE),
        .trn_op    (TRN_OP),
        .trn_steps (TRN_STEPS),
        .vt_req    (VT_REQ),
        .vt_lane   (VT_LANE),
        .vt_op     (VT_OP),
        .vt_steps  (VT_STEPS),
        .done      (state == S_DONE),
        .trn_gnt   (TRN_GNT),
        .vt_gnt    (VT_GNT),
        .gnt       (gnt),
        .sel_lane  (sel_lane),
        .sel_op    (sel_op),
        .sel_steps (sel_steps),
        .cap_lane  (cap_lane),
        .cap_op    (cap_op),
        .trn_done  (TRN_DONE),
        .vt_done   (VT_DONE)
    );

    // Shadow lookup for the active lane and for readback
    always_comb begin
        cur_tap = '0;
        rd_sel  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (LANE_W'(i) == cap_lane) cur_tap = shadow[i];
            if (LANE_W'(i) == RD_LANE)  rd_sel  = shadow[i];
        end
    end

    // Per-step conditions of the active lane
    always_comb begin
        lane_oh     = NUM_LANES'(1) << cap_lane;
        sat         = (cap_op == OP_INC) ?
                      (cur_tap == TAP_W'(MAX_TAP)) :
                      (cur_tap == '0);
        oor_hit     = |(DELAY_LINE_OUT_OF_RANGE & lane_oh);
        gap_last    = gap_cnt == GAP_W'(MOVE_GAP - 1);
        move_fire   = (state == S_MOVE) && !sat;
        step_commit = (state == S_GAP) && gap_last && !oor_hit;
    end

    // Next state and abort flag
    always_comb begin
        state_d    = state;
        done_err_d = done_err_q;
        dir_load   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (gnt) begin
                    done_err_d = 1'b0;
                    if (!sel_ok) begin
                        state_d    = S_DONE;
                        done_err_d = 1'b1;
                    end else if (sel_op == OP_LOAD) begin
                        state_d = S_LOAD;
                    end else if (sel_op == OP_NOP || sel_steps == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_SETDIR;
                        dir_load = 1'b1;
                    end
                end
            end
            S_LOAD:   state_d = S_DONE;
            S_SETDIR: state_d = S_MOVE;
            S_MOVE: begin
                if (sat) begin
                    state_d    = S_DONE;
                    done_err_d = 1'b1;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (oor_hit) begin
                    state_d    = S_DONE;
                    done_err_d = 1'b1;
                end else if (gap_last) begin
                    state_d = (steps_left == '0) ? S_DONE : S_MOVE;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM state, step/gap counters and direction register
    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            state      <= S_IDLE;
            done_err_q <= 1'b0;
            steps_left <= '0;
            gap_cnt    <= '0;
            dir_q      <= '0;
        end else begin
            state      <= state_d;
            done_err_q <= done_err_d;
            if (gnt)
                steps_left <= sel_steps;
            else if (move_fire)
                steps_left <= steps_left - TAP_W'(1);
            if (state == S_MOVE)
                gap_cnt <= '0;
            else if (state == S_GAP)
                gap_cnt <= gap_cnt + GAP_W'(1);
            for (int i = 0; i < NUM_LANES; i++)
                if (dir_load && LANE_W'(i) == sel_lane)
                    dir_q[i] <= (sel_op == OP_INC) ? DIR_INC : ~DIR_INC;
        end
    end

    // Shadow taps track LOADs and every completed step
    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_LANES; i++)
                shadow[i] <= TAP_W'(LOAD_VAL);
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (LANE_W'(i) == cap_lane) begin
                    if (state == S_LOAD)
                        shadow[i] <= TAP_W'(LOAD_VAL);
                    else if (step_commit)
                        shadow[i] <= (cap_op == OP_INC) ?
                                     shadow[i] + TAP_W'(1) :
                                     shadow[i] - TAP_W'(1);
                end
            end
        end
    end

    // Registered shadow readback
    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N)
            RD_TAP <= TAP_W'(LOAD_VAL);
        else
            RD_TAP <= rd_sel;
    end

    assign DELAY_LINE_LOAD      = (state == S_LOAD) ? lane_oh : '0;
    assign DELAY_LINE_MOVE      = move_fire ? lane_oh : '0;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DONE_ERR             = (state == S_DONE) && done_err_q;
    assign BUSY                 = state != S_IDLE;

endmodule

// File: tb/tb_ddr3_ca_delay_line_ctrl.sv
// Bench for ddr3_ca_delay_line_ctrl: per-operation timeline
// predicted from the sequencing rules, compared cycle by cycle.
module tb_ddr3_ca_delay_line_ctrl;

    logic        FAB_CLK = 1'b0;
    logic        RESET_N;
    logic        TRN_REQ, VT_REQ;
    logic [3:0]  TRN_LANE, VT_LANE;
    logic [1:0]  TRN_OP, VT_OP;
    logic [7:0]  TRN_STEPS, VT_STEPS;
    logic        TRN_GNT, TRN_DONE, VT_GNT, VT_DONE, DONE_ERR;
    logic [13:0] DELAY_LINE_LOAD, DELAY_LINE_MOVE;
    logic [13:0] DELAY_LINE_DIRECTION, DELAY_LINE_OUT_OF_RANGE;
    logic [3:0]  RD_LANE;
    logic [7:0]  RD_TAP;
    logic        BUSY;

    int total = 0;
    int bad   = 0;

    logic [7:0]  sh_m [16];
    logic [13:0] dir_m;
    bit          arm_vt;
    logic [3:0]  arm_lane;
    logic [1:0]  arm_op;
    logic [7:0]  arm_steps;

    ddr3_ca_delay_line_ctrl dut (
        .FAB_CLK                 (FAB_CLK),
        .RESET_N                 (RESET_N),
        .TRN_REQ                 (TRN_REQ),
        .TRN_LANE                (TRN_LANE),
        .TRN_OP                  (TRN_OP),
        .TRN_STEPS               (TRN_STEPS),
        .TRN_GNT                 (TRN_GNT),
        .TRN_DONE                (TRN_DONE),
        .VT_REQ                  (VT_REQ),
        .VT_LANE                 (VT_LANE),
        .VT_OP                   (VT_OP),
        .VT_STEPS                (VT_STEPS),
        .VT_GNT                  (VT_GNT),
        .VT_DONE                 (VT_DONE),
        .DONE_ERR                (DONE_ERR),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
        .RD_LANE                 (RD_LANE),
        .RD_TAP                  (RD_TAP),
        .BUSY                    (BUSY)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    task automatic do_op(input bit vt, input logic [1:0] op,
                         input logic [3:0] lane, input int steps,
                         input int oor_k, input string name,
                         output int waits);
        int mv[$];
        int done_c, ld_c, oor_c, k;
        bit err, gnt_seen, in_mv;
        int t;
        logic [13:0] oh, exp_mv, exp_ld;
        logic own_gnt, oth_gnt, own_done, oth_done;

        oh = (lane < 14) ? (14'(1) << lane) : 14'(0);
        ld_c = -1; oor_c = -1; err = 0;
        if (lane >= 14) begin
            done_c = 1; err = 1;
        end else if (op == 2'b00) begin
            ld_c = 1; done_c = 2; sh_m[lane] = 8'd1;
        end else if (op == 2'b11 || steps == 0) begin
            done_c = 1;
        end else begin
            t = int'(sh_m[lane]);
            done_c = 2 + steps * 3;
            dir_m[lane] = (op == 2'b01);
            for (k = 0; k < steps; k++) begin
                if ((op == 2'b01 && t == 255) || (op == 2'b10 && t == 0)) begin
                    done_c = 2 + k * 3 + 1; err = 1;
                    break;
                end
                mv.push_back(2 + k * 3);
                if (k == oor_k) begin
                    oor_c = 2 + k * 3 + 1;
                    done_c = 2 + k * 3 + 2; err = 1;
                    break;
                end
                t = (op == 2'b01) ? t + 1 : t - 1;
            end
            sh_m[lane] = 8'(t);
        end

        waits = 0; gnt_seen = 0;
        for (int w = 0; w < 10 && !gnt_seen; w++) begin
            @(negedge FAB_CLK);
            if (vt) begin
                VT_REQ = 1; VT_LANE = lane; VT_OP = op; VT_STEPS = 8'(steps);
            end else begin
                TRN_REQ = 1; TRN_LANE = lane; TRN_OP = op; TRN_STEPS = 8'(steps);
            end
            if (arm_vt) begin
                VT_REQ = 1; VT_LANE = arm_lane; VT_OP = arm_op; VT_STEPS = arm_steps;
                arm_vt = 0;
            end
            #1;
            own_gnt = vt ? VT_GNT : TRN_GNT;
            oth_gnt = vt ? TRN_GNT : VT_GNT;
            if (own_gnt === 1'b1) gnt_seen = 1;
            else waits++;
        end
        total++;
        if (!gnt_seen) begin
            bad++;
            $display("FAIL %s gnt_timeout got=0 exp=1", name);
        end
        total++;
        if (oth_gnt !== 1'b0) begin
            bad++;
            $display("FAIL %s other_gnt c=0 got=%b exp=0", name, oth_gnt);
        end

        for (int c = 1; gnt_seen && c <= done_c; c++) begin
            @(negedge FAB_CLK);
            if (c == 1) begin
                if (vt) VT_REQ = 0; else TRN_REQ = 0;
            end
            DELAY_LINE_OUT_OF_RANGE = (oor_c >= 0 && c >= oor_c && c < done_c) ? oh : 14'(0);
            #1;
            in_mv = 0;
            foreach (mv[i]) if (mv[i] == c) in_mv = 1;
            exp_mv = in_mv ? oh : 14'(0);
            exp_ld = (c == ld_c) ? oh : 14'(0);
            own_gnt  = vt ? VT_GNT : TRN_GNT;
            oth_gnt  = vt ? TRN_GNT : VT_GNT;
            own_done = vt ? VT_DONE : TRN_DONE;
            oth_done = vt ? TRN_DONE : VT_DONE;
            total++;
            if (DELAY_LINE_MOVE !== exp_mv) begin
                bad++;
                $display("FAIL %s move c=%0d got=%h exp=%h", name, c, DELAY_LINE_MOVE, exp_mv);
            end
            total++;
            if (DELAY_LINE_LOAD !== exp_ld) begin
                bad++;
                $display("FAIL %s load c=%0d got=%h exp=%h", name, c, DELAY_LINE_LOAD, exp_ld);
            end
            total++;
            if (DELAY_LINE_DIRECTION !== dir_m) begin
                bad++;
                $display("FAIL %s dir c=%0d got=%h exp=%h", name, c, DELAY_LINE_DIRECTION, dir_m);
            end
            total++;
            if (own_done !== (c == done_c)) begin
                bad++;
                $display("FAIL %s done c=%0d got=%b exp=%b", name, c, own_done, c == done_c);
            end
            total++;
            if (DONE_ERR !== ((c == done_c) ? err : 1'b0)) begin
                bad++;
                $display("FAIL %s done_err c=%0d got=%b exp=%b", name, c, DONE_ERR,
                         (c == done_c) ? err : 1'b0);
            end
            total++;
            if (oth_done !== 1'b0 || own_gnt !== 1'b0 || oth_gnt !== 1'b0) begin
                bad++;
                $display("FAIL %s stray c=%0d got=%b%b%b exp=000", name, c,
                         oth_done, own_gnt, oth_gnt);
            end
            total++;
            if (BUSY !== 1'b1) begin
                bad++;
                $display("FAIL %s busy c=%0d got=%b exp=1", name, c, BUSY);
            end
        end
        DELAY_LINE_OUT_OF_RANGE = '0;
    endtask

    task automatic read_tap(input logic [3:0] lane, input string name);
        @(negedge FAB_CLK);
        RD_LANE = lane;
        #1;
        total++;
        if (BUSY !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_busy got=%b exp=0", name, BUSY);
        end
        @(negedge FAB_CLK);
        #1;
        total++;
        if (RD_TAP !== sh_m[lane]) begin
            bad++;
            $display("FAIL %s rd_tap lane=%0d got=%0d exp=%0d", name, lane, RD_TAP, sh_m[lane]);
        end
    endtask

    task automatic test_reset;
        RESET_N = 0; TRN_REQ = 0; VT_REQ = 0;
        TRN_LANE = 0; TRN_OP = 0; TRN_STEPS = 0;
        VT_LANE = 0; VT_OP = 0; VT_STEPS = 0;
        DELAY_LINE_OUT_OF_RANGE = '0; RD_LANE = 0; arm_vt = 0;
        for (int i = 0; i < 16; i++) sh_m[i] = 8'd1;
        dir_m = '0;
        repeat (3) @(negedge FAB_CLK);
        RESET_N = 1;
        RD_LANE = 4'd5;
        #1;
        total++;
        if ({DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION} !== 42'd0) begin
            bad++;
            $display("FAIL reset pulses got=%h exp=0",
                     {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION});
        end
        total++;
        if ({BUSY, TRN_GNT, VT_GNT, TRN_DONE, VT_DONE, DONE_ERR} !== 6'd0) begin
            bad++;
            $display("FAIL reset ctl got=%b exp=0",
                     {BUSY, TRN_GNT, VT_GNT, TRN_DONE, VT_DONE, DONE_ERR});
        end
        @(negedge FAB_CLK);
        #1;
        total++;
        if (RD_TAP !== 8'd1) begin
            bad++;
            $display("FAIL reset rd_tap got=%0d exp=1", RD_TAP);
        end
    endtask

    task automatic test_inc;
        int w;
        do_op(0, 2'b01, 4'd3, 3, -1, "inc3", w);
        read_tap(4'd3, "inc3");
    endtask

    task automatic test_arbitration;
        int w;
        arm_vt = 1; arm_lane = 4'd0; arm_op = 2'b10; arm_steps = 8'd1;
        do_op(0, 2'b00, 4'd5, 0, -1, "arb_trn", w);
        do_op(1, 2'b10, 4'd0, 1, -1, "arb_vt", w);
        total++;
        if (w != 0) begin
            bad++;
            $display("FAIL arb vt_gnt_delay got=%0d exp=0", w);
        end
        read_tap(4'd0, "arb_vt");
    endtask

    task automatic test_saturation;
        int w;
        do_op(1, 2'b00, 4'd0, 0, -1, "sat_load", w);
        do_op(1, 2'b10, 4'd0, 2, -1, "sat_dec", w);
        read_tap(4'd0, "sat_dec");
        do_op(0, 2'b01, 4'd9, 255, -1, "sat_max", w);
        read_tap(4'd9, "sat_max");
        do_op(1, 2'b10, 4'd9, 2, -1, "dec_from_max", w);
        read_tap(4'd9, "dec_from_max");
    endtask

    task automatic test_out_of_range;
        int w;
        do_op(0, 2'b01, 4'd7, 4, 1, "oor7", w);
        read_tap(4'd7, "oor7");
    endtask

    task automatic test_boundaries;
        int w;
        do_op(0, 2'b01, 4'd14, 3, -1, "bad_lane14", w);
        do_op(1, 2'b00, 4'd15, 0, -1, "bad_lane15", w);
        do_op(0, 2'b11, 4'd2, 5, -1, "nop", w);
        do_op(1, 2'b01, 4'd2, 0, -1, "zero_steps", w);
        read_tap(4'd2, "zero_steps");
        do_op(1, 2'b01, 4'd13, 1, -1, "lane13", w);
        read_tap(4'd13, "lane13");
    endtask

    task automatic test_random;
        int w, oor_k, steps;
        bit vt;
        logic [1:0] op;
        logic [3:0] lane;
        for (int n = 0; n < 40; n++) begin
            vt    = 1'($urandom_range(0, 1));
            op    = 2'($urandom_range(0, 3));
            lane  = 4'($urandom_range(0, 15));
            steps = $urandom_range(0, 5);
            oor_k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
            do_op(vt, op, lane, steps, oor_k, "rand", w);
            if (lane < 14) read_tap(lane, "rand");
        end
    endtask

    task automatic test_reset_mid;
        int w;
        @(negedge FAB_CLK);
        TRN_REQ = 1; TRN_LANE = 4'd3; TRN_OP = 2'b01; TRN_STEPS = 8'd3;
        #1;
        total++;
        if (TRN_GNT !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid gnt got=%b exp=1", TRN_GNT);
        end
        @(negedge FAB_CLK);
        TRN_REQ = 0;
        @(negedge FAB_CLK);
        @(negedge FAB_CLK);
        RESET_N = 0;
        @(negedge FAB_CLK);
        RESET_N = 1;
        RD_LANE = 4'd3;
        for (int i = 0; i < 16; i++) sh_m[i] = 8'd1;
        dir_m = '0;
        #1;
        total++;
        if ({DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION} !== 42'd0) begin
            bad++;
            $display("FAIL rst_mid pulses got=%h exp=0",
                     {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION});
        end
        total++;
        if ({BUSY, TRN_DONE, VT_DONE, DONE_ERR} !== 4'd0 || RD_TAP !== 8'd1) begin
            bad++;
            $display("FAIL rst_mid ctl got=%b/%0d exp=0/1",
                     {BUSY, TRN_DONE, VT_DONE, DONE_ERR}, RD_TAP);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge FAB_CLK);
            #1;
            total++;
            if ({BUSY, TRN_DONE, VT_DONE, DELAY_LINE_MOVE} !== 17'd0) begin
                bad++;
                $display("FAIL rst_mid quiet c=%0d got=%h exp=0", c,
                         {BUSY, TRN_DONE, VT_DONE, DELAY_LINE_MOVE});
            end
        end
        read_tap(4'd3, "rst_mid");
        do_op(0, 2'b01, 4'd3, 2, -1, "post_rst_inc", w);
        do_op(0, 2'b00, 4'd3, 0, -1, "post_rst_load", w);
        read_tap(4'd3, "post_rst_load");
    endtask

    initial begin
        test_reset();
        test_inc();
        test_arbitration();
        test_saturation();
        test_out_of_range();
        test_boundaries();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
